// File: rtl/relu_bwd.sv
// ReLU backward stage: captures forward sign masks in a FIFO and gates gradients by them.
// Optional zero-gradient counter is enabled by defining RELU_BWD_ZCNT_EN.
module relu_bwd #(
  parameter int NUM_WIDTH = 16,
  parameter int DEPTH     = 64,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bypass,
  input  logic                 mask_valid,
  output logic                 mask_ready,
  input  logic [NUM_WIDTH-1:0] mask_data,
  input  logic                 bwd_start,
  input  logic                 grad_valid,
  output logic                 grad_ready,
  input  logic [NUM_WIDTH-1:0] grad_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [NUM_WIDTH-1:0] dn_data,
  output logic                 bwd_done,
  output logic [CNT_W-1:0]     mask_count
`ifdef RELU_BWD_ZCNT_EN
  ,
  output logic [15:0]          zero_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {S_FWD, S_BWD} state_t;

  state_t               state_q, state_d;
  logic [DEPTH-1:0]     mem_q, mem_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 dn_valid_q, dn_valid_d;
  logic [NUM_WIDTH-1:0] dn_data_q, dn_data_d;
  logic                 bwd_done_q, bwd_done_d;

  logic mask_ready_c;
  logic grad_ready_c;
  logic wr_en;
  logic pop;
  logic pop_mask;
  logic out_free;

  // Only the sign bit of the pre-activation word is kept.
  logic unused_mask_bits;
  assign unused_mask_bits = ^mask_data[NUM_WIDTH-2:0];

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dn_valid_d = dn_valid_q;
    dn_data_d  = dn_data_q;
    bwd_done_d = 1'b0;

    out_free     = !dn_valid_q || dn_ready;
    mask_ready_c = (state_q == S_FWD) && (count_q != CNT_W'(DEPTH));
    grad_ready_c = (state_q == S_BWD) && (count_q != '0) && out_free;
    wr_en        = mask_valid && mask_ready_c;
    pop          = grad_valid && grad_ready_c;
    pop_mask     = mem_q[rd_ptr_q];

    if (wr_en) begin
      mem_d[wr_ptr_q] = ~mask_data[NUM_WIDTH-1];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      count_d         = count_q + CNT_W'(1);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      count_d    = count_q - CNT_W'(1);
      dn_valid_d = 1'b1;
      dn_data_d  = (bypass || pop_mask) ? grad_data : '0;
    end else if (dn_ready) begin
      dn_valid_d = 1'b0;
    end

    // An empty FIFO at bwd_start ends the phase without ever leaving S_FWD.
    case (state_q)
      S_FWD: begin
        if (bwd_start) begin
          if (count_q == '0) begin
            bwd_done_d = 1'b1;
          end else begin
            state_d = S_BWD;
          end
        end
      end
      S_BWD: begin
        if ((count_q == '0) && out_free) begin
          bwd_done_d = 1'b1;
          state_d    = S_FWD;
        end
      end
      default: state_d = S_FWD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FWD;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dn_valid_q <= 1'b0;
      dn_data_q  <= '0;
      bwd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dn_valid_q <= dn_valid_d;
      dn_data_q  <= dn_data_d;
      bwd_done_q <= bwd_done_d;
    end
  end

`ifdef RELU_BWD_ZCNT_EN
  logic [15:0] zero_cnt_q, zero_cnt_d;

  // Counts gradients zeroed by the mask; saturates and holds until the next phase starts.
  always_comb begin
    zero_cnt_d = zero_cnt_q;
    if ((state_q == S_FWD) && bwd_start) begin
      zero_cnt_d = '0;
    end else if (pop && !bypass && !pop_mask && (zero_cnt_q != 16'hFFFF)) begin
      zero_cnt_d = zero_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt_q <= '0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign zero_cnt = zero_cnt_q;
`endif

  assign mask_ready = mask_ready_c;
  assign grad_ready = grad_ready_c;
  assign dn_valid   = dn_valid_q;
  assign dn_data    = dn_data_q;
  assign bwd_done   = bwd_done_q;
  assign mask_count = count_q;

endmodule

// File: doc/relu_bwd.md
Name: relu_bwd

Overview:
- Backward-pass companion of the ReLU activation stage.
- During the forward pass it snoops the pre-activation values entering ReLU and stores one mask bit per element (sign-bit clear = 1) in a FIFO.
- During the backward pass it pops one mask bit per incoming gradient and outputs either the gradient or zero.
- Sits between the loss/gradient stream and the upstream layer's gradient input.

Parameters:
- NUM_WIDTH, 16, width of pre-activation and gradient words (two's complement).
- DEPTH, 64, mask FIFO entries; must be a power of 2, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bypass  in  1  when 1, the gradient passes through unchanged; the mask is still popped.
- mask_valid  in  1  forward pre-activation word present.
- mask_ready  out  1  mask FIFO can accept a word.
- mask_data  in  NUM_WIDTH  forward pre-activation value; only the MSB is stored.
- bwd_start  in  1  single-cycle pulse that enters the backward phase.
- grad_valid  in  1  gradient word present.
- grad_ready  out  1  gradient can be accepted.
- grad_data  in  NUM_WIDTH  incoming gradient.
- dn_valid  out  1  output gradient valid (registered).
- dn_ready  in  1  downstream accepts the output.
- dn_data  out  NUM_WIDTH  output gradient (registered).
- bwd_done  out  1  single-cycle pulse when the backward phase ends.
- mask_count  out  CNT_W  number of stored mask bits.

Behaviour:
- Reset (async, rst=1):
  - state=S_FWD; read/write pointers and mask_count = 0.
  - dn_valid=0, dn_data=0, bwd_done=0.
  - FIFO contents are discarded.
  - A reset in the middle of either phase aborts it; no partial output is produced after rst deasserts.
- Mask bit = ~mask_data[NUM_WIDTH-1]. A zero input gives mask 1, matching forward ReLU, which passes 0.
- State S_FWD:
  - mask_ready = (mask_count != DEPTH).
  - Write on mask_valid && mask_ready.
  - grad_ready=0.
  - bwd_start moves to S_BWD on the next edge. If mask_count==0 at bwd_start, stay in S_FWD and pulse bwd_done on the next cycle instead.
- State S_BWD:
  - mask_ready=0; mask words are held off, never dropped.
  - grad_ready = (mask_count != 0) && (!dn_valid || dn_ready).
  - On grad_valid && grad_ready: pop one mask bit. Next cycle dn_data = (bypass || mask) ? grad_data : 0, and dn_valid=1.
  - Latency is 1 cycle. Throughput is 1 word/cycle while dn_ready=1.
- Output register:
  - Holds dn_data and dn_valid stable while dn_valid && !dn_ready.
  - Clears dn_valid on handshake unless a new word loads in the same cycle.
- Backward phase end:
  - When mask_count==0 and no output is pending (the last dn handshake completes), pulse bwd_done for 1 cycle and return to S_FWD.
  - Mask capture resumes the following cycle.
- Edge cases:
  - bwd_start while already in S_BWD is ignored.
  - Simultaneous write and pop cannot occur, because the phases are exclusive.
  - Pointers wrap modulo DEPTH.
  - mask_count is exact at full (DEPTH) and empty (0).
- Extra gradients arriving after the mask empties are stalled (grad_ready=0) until the next backward phase.
- Elements are processed in order: the k-th gradient pairs with the k-th captured mask.

Optional Feature:
- Macro RELU_BWD_ZCNT_EN.
- When defined, adds output port zero_cnt [15:0]:
  - Counts gradients forced to zero (mask=0 && !bypass) in the current backward phase.
  - Clears to 0 on reset and on an accepted bwd_start.
  - Saturates at 16'hFFFF.
  - Holds its value after bwd_done until the next bwd_start.
- When not defined: no port, no counter logic; behaviour is otherwise identical.

Test Plan:
- Capture masks from inputs 16'h0005, 16'hFFFB, 16'h0000, 16'h8000, then bwd_start, then gradients 16'h0010, 16'h0020, 16'h0030, 16'h0040 with dn_ready=1 -> dn_data 16'h0010, 0, 16'h0030, 0, each 1 cycle after acceptance; bwd_done pulses once; mask_count returns to 0.
- Same masks with bypass=1 -> dn_data 16'h0010, 16'h0020, 16'h0030, 16'h0040.
- Write 64 masks with mask_valid held high -> mask_ready falls after the 64th; the 65th word is not written; mask_count=64. A full backward pass of 64 gradients then wraps the pointers, and a second fill works.
- Backward pass with dn_ready toggling 1,0,0,1 -> dn_data stable while stalled; grad_ready=0 during the stall; no word lost or duplicated.
- bwd_start with an empty FIFO -> bwd_done pulses next cycle, state stays S_FWD, grad_ready stays 0.
- Assert rst after 2 of 4 backward outputs -> dn_valid=0 and mask_count=0 immediately; after release, mask_ready=1. With RELU_BWD_ZCNT_EN defined, zero_cnt=0 after reset, and equals 2 after the first scenario.
